// File: rtl/periph_axil2apb_pkg.sv
// Shared types and constants for the AXI4-Lite to APB manager bridge.
package periph_axil2apb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StWresp,
    StRresp
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/periph_axil2apb_mgr.sv
// AXI4-Lite subordinate to APB manager bridge: one transfer in flight, round-robin
// read/write arbitration, APB error and access watchdog reported as SLVERR.
module periph_axil2apb_mgr
  import periph_axil2apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic [1:0]              bresp_o,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    psuberr_i
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic                  prio_wr_q, prio_wr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [StrbW-1:0]      pstrb_q, pstrb_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [1:0]            rresp_q, rresp_d;

  logic wr_elig, rd_elig, grant_wr, grant_rd, timeout_hit;

  assign wr_elig     = awvalid_i & wvalid_i;
  assign rd_elig     = arvalid_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pwrite_d  = pwrite_q;
    rdata_d   = rdata_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Grants are gated by reset so every output reads 0 while it is held.
        if (rstn_i) begin
          if (wr_elig && (!rd_elig || prio_wr_q)) begin
            grant_wr = 1'b1;
          end else if (rd_elig) begin
            grant_rd = 1'b1;
          end
        end
        if (grant_wr || grant_rd) begin
          paddr_d   = grant_wr ? awaddr_i : araddr_i;
          pwrite_d  = grant_wr;
          pwdata_d  = grant_wr ? wdata_i : '0;
          pstrb_d   = grant_wr ? wstrb_i : '0;
          prio_wr_d = grant_rd;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        // A pready arriving on the timeout cycle still completes normally.
        if (pready_i || timeout_hit) begin
          if (pwrite_q) begin
            bresp_d = (pready_i && !psuberr_i) ? RESP_OKAY : RESP_SLVERR;
            state_d = StWresp;
          end else begin
            rresp_d = (pready_i && !psuberr_i) ? RESP_OKAY : RESP_SLVERR;
            rdata_d = pready_i ? prdata_i : '0;
            state_d = StRresp;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWresp: if (bready_i) state_d = StIdle;
      StRresp: if (rready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      prio_wr_q <= 1'b0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pwrite_q  <= 1'b0;
      rdata_q   <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pwrite_q  <= pwrite_d;
      rdata_q   <= rdata_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
    end
  end

  assign awready_o = grant_wr;
  assign wready_o  = grant_wr;
  assign arready_o = grant_rd;
  assign psel_o    = (state_q == StSetup) || (state_q == StAccess);
  assign penable_o = (state_q == StAccess);
  assign bvalid_o  = (state_q == StWresp);
  assign rvalid_o  = (state_q == StRresp);
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pstrb_o   = pstrb_q;
  assign rdata_o   = rdata_q;
  assign bresp_o   = bresp_q;
  assign rresp_o   = rresp_q;

endmodule
